usr_frame_shifter: RTL
======================

USR_FRAME_SHIFTER -- requirements
Module: usr_frame_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 11, giving the register length in bits (WIDTH >= 2).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), giving the bit-counter width; it is derived, not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its falling edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port load, input, 1 bit: parallel load request.
REQ-006 SHALL have port shift, input, 1 bit: one-position shift request.
REQ-007 SHALL have port dir, input, 1 bit: 0 = shift right (toward bit 0), 1 = shift left.
REQ-008 SHALL have port sl_in, input, 1 bit: serial bit entering the MSB on a right shift.
REQ-009 SHALL have port sr_in, input, 1 bit: serial bit entering the LSB on a left shift.
REQ-010 SHALL have port par_load, input, WIDTH bits: parallel load data.
REQ-011 SHALL have port data_out, output, WIDTH bits: current register contents.
REQ-012 SHALL have port ser_out, output, 1 bit: the bit that the next shift expels (storage[0] if dir=0, storage[WIDTH-1] if dir=1), combinational.
REQ-013 SHALL have port bit_cnt, output, CNT_W bits: number of shifts since the last load, reset or frame restart.
REQ-014 SHALL have port full, output, 1 bit: high while bit_cnt == WIDTH.
REQ-015 SHALL have port frame_done, output, 1 bit: registered single-cycle pulse marking completion of WIDTH shifts.
REQ-016 SHALL have port parity_out, output, 1 bit: XOR of all data_out bits (see Configuration).

Function
REQ-017 SHALL apply the priority RST > load > shift > hold at each falling edge of clk.
REQ-018 On load, SHALL set storage to par_load, set bit_cnt to 0 and set frame_done to 0.
REQ-019 On shift with dir=0, SHALL set storage to {sl_in, storage[WIDTH-1:1]}.
REQ-020 On shift with dir=1, SHALL set storage to {storage[WIDTH-2:0], sr_in}.
REQ-021 On shift with bit_cnt < WIDTH, SHALL increment bit_cnt by 1.
REQ-022 On shift with bit_cnt == WIDTH, SHALL set bit_cnt to 1, starting a new frame; there is no wrap through 0.
REQ-023 SHALL set frame_done to 1 for exactly one cycle on the edge where bit_cnt changes from WIDTH-1 to WIDTH, and to 0 on every other edge.
REQ-024 SHALL hold storage and bit_cnt when neither load nor shift is asserted.
REQ-025 SHALL cause a dir change between shifts to affect only subsequent shifts and ser_out; a dir change SHALL NOT reset bit_cnt.
REQ-026 When load and shift are asserted together, SHALL perform the load only.

Reset
REQ-027 With RST high at a falling edge, SHALL set storage, bit_cnt and frame_done to 0, regardless of load and shift.
REQ-028 When RST is asserted mid-frame, SHALL discard the partial frame and SHALL NOT emit frame_done.
REQ-029 After reset, SHALL drive data_out=0, ser_out=0, bit_cnt=0, full=0, frame_done=0 and parity_out=0.

Configuration
REQ-030 With macro USR_PARITY_EN defined, SHALL drive parity_out as the XOR reduction of storage, updating combinationally with data_out.
REQ-031 Without USR_PARITY_EN, SHALL tie parity_out to constant 0 and include no parity logic.

Structure
REQ-032 SHALL take from shared package usr_pkg the constants DIR_RIGHT=1'b0 and DIR_LEFT=1'b1 and a clog2 helper function.
REQ-033 SHALL place the bit counter, full and frame_done logic in one sub-module, usr_bit_counter, with inputs clk, RST, clr (= load), inc (= shift & ~load), parameterised by WIDTH.

Verification (WIDTH=11)
REQ-034 SHALL cover: RST high for one edge with load=shift=1 -> data_out=0x000, bit_cnt=0, frame_done=0.
REQ-035 SHALL cover: load par_load=0x5A3 -> data_out=0x5A3 and bit_cnt=0 after one edge; with dir=0, ser_out=1.
REQ-036 SHALL cover: from 0x000, 11 right shifts with sl_in=1 -> data_out=0x7FF, bit_cnt=11, full=1, frame_done high only after edge 11; a 12th shift -> bit_cnt=1, frame_done=0.
REQ-037 SHALL cover: load=1, shift=1, par_load=0x155 -> data_out=0x155, bit_cnt=0.
REQ-038 SHALL cover: load 0x400, dir=1 -> ser_out=1; one shift with sr_in=0 -> data_out=0x000, ser_out=0, bit_cnt=1.
REQ-039 SHALL cover: load 0x007 -> parity_out=1 with USR_PARITY_EN defined, 0 without; RST after 5 shifts -> no frame_done pulse.

Source files
------------

// File: rtl/usr_pkg.sv
// ============================================================================
// Module : usr_pkg
// Brief  : Shared direction constants and a clog2 helper for the usr_* blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package usr_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Elaboration-time ceil(log2(value)), with a minimum result of 1 bit
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage : usr_pkg

`default_nettype wire

// File: rtl/usr_bit_counter.sv
// ============================================================================
// Module : usr_bit_counter
// Brief  : Shift counter with full flag and a one-cycle frame-complete pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module usr_bit_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_PRE = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;

    // A shift taken while full begins the next frame at 1, never passing through 0
    always_ff @(negedge clk) begin
        if (RST) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (clr) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (inc) begin
            r_cnt        <= (r_cnt == C_CNT_MAX) ? C_CNT_ONE : (r_cnt + C_CNT_ONE);
            r_frame_done <= (r_cnt == C_CNT_PRE);
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign cnt        = r_cnt;
    assign full       = (r_cnt == C_CNT_MAX);
    assign frame_done = r_frame_done;

endmodule : usr_bit_counter

`default_nettype wire

// File: rtl/usr_frame_shifter.sv
// ============================================================================
// Module : usr_frame_shifter
// Brief  : Bidirectional loadable shift register with frame counting.
//          Define USR_PARITY_EN to enable the parity_out reduction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module usr_frame_shifter
    import usr_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic             sl_in,
    input  logic             sr_in,
    input  logic [WIDTH-1:0] par_load,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             full,
    output logic             frame_done,
    output logic             parity_out
);

    logic [WIDTH-1:0] r_storage;
    logic [WIDTH-1:0] w_storage_nxt;
    logic             w_inc;

    assign w_inc = shift & ~load;

    always_comb begin
        w_storage_nxt = r_storage;
        if (load) begin
            w_storage_nxt = par_load;
        end else if (shift) begin
            if (dir == DIR_LEFT) begin
                w_storage_nxt = {r_storage[WIDTH-2:0], sr_in};
            end else begin
                w_storage_nxt = {sl_in, r_storage[WIDTH-1:1]};
            end
        end
    end

    always_ff @(negedge clk) begin
        if (RST) begin
            r_storage <= '0;
        end else begin
            r_storage <= w_storage_nxt;
        end
    end

    usr_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .RST        (RST),
        .clr        (load),
        .inc        (w_inc),
        .cnt        (bit_cnt),
        .full       (full),
        .frame_done (frame_done)
    );

    assign data_out = r_storage;
    // ser_out previews the bit the next shift in the current direction expels
    assign ser_out  = (dir == DIR_LEFT) ? r_storage[WIDTH-1] : r_storage[0];

`ifdef USR_PARITY_EN
    assign parity_out = ^r_storage;
`else
    assign parity_out = 1'b0;
`endif

endmodule : usr_frame_shifter

`default_nettype wire
